// File: rtl/sobel_stream_ctrl_if.sv
// sobel_stream_ctrl_if
//   Handshake and status bundle between a pixel source / Sobel datapath and
//   the sobel_stream_ctrl frame sequencer.
//   Optional build macro: SOBEL_CTRL_OVF_EN (adds drop_err / drop_cnt).
//
//   input_data_valid  source -> ctrl   pixel present this cycle
//   in_ready          ctrl -> source   input accepted this cycle
//   pipe_en, flush    ctrl -> datapath advance strobe / inject-zero strobe
//   out_valid, out_col, out_row, border, eol, eof
//                     ctrl -> datapath registered output pixel tags
//   frame_done, busy  ctrl -> system   frame status
//   drop_err, drop_cnt (SOBEL_CTRL_OVF_EN only) dropped-input monitor
//
//   master: the pixel source / datapath side; slave: the controller.

interface sobel_stream_ctrl_if #(
  parameter int CNT_W = 12
) ();
  logic             input_data_valid;
  logic             in_ready;
  logic             pipe_en;
  logic             flush;
  logic             out_valid;
  logic [CNT_W-1:0] out_col;
  logic [CNT_W-1:0] out_row;
  logic             border;
  logic             eol;
  logic             eof;
  logic             frame_done;
  logic             busy;
`ifdef SOBEL_CTRL_OVF_EN
  logic             drop_err;
  logic [15:0]      drop_cnt;
`endif

  modport master (
    output input_data_valid,
    input  in_ready, pipe_en, flush, out_valid, out_col, out_row,
           border, eol, eof, frame_done, busy
`ifdef SOBEL_CTRL_OVF_EN
    , input drop_err, drop_cnt
`endif
  );

  modport slave (
    input  input_data_valid,
    output in_ready, pipe_en, flush, out_valid, out_col, out_row,
           border, eol, eof, frame_done, busy
`ifdef SOBEL_CTRL_OVF_EN
    , output drop_err, drop_cnt
`endif
  );
endinterface

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl
//   Frame sequencer for the Sobel 3x3 filter datapath. Counts accepted input
//   pixels in raster order, issues the datapath advance strobe (pipe_en),
//   tracks the output raster position (lagging input by one line plus one
//   pixel), tags border pixels, and after the last input pixel generates
//   flush strobes so each frame yields exactly IMAGE_WIDTH*IMAGE_HEIGHT
//   outputs.
//   Optional build macro: SOBEL_CTRL_OVF_EN (sticky drop_err and saturating
//   16-bit drop_cnt for inputs offered while in_ready=0).
//
// Ports
//   clk     system clock, rising edge
//   resetn  asynchronous reset, ACTIVE-HIGH despite the name (1 = in reset)
//   bus     sobel_stream_ctrl_if.slave; see interface file for signal list

module sobel_stream_ctrl #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int CNT_W        = 12
) (
  input  logic                 clk,
  input  logic                 resetn,
  sobel_stream_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_COL   = CNT_W'(IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(IMAGE_HEIGHT - 1);
  // LAG-1 where LAG = IMAGE_WIDTH+1
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(IMAGE_WIDTH);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] in_col_q, in_col_d;
  logic [CNT_W-1:0] in_row_q, in_row_d;
  logic [CNT_W-1:0] oc_q, oc_d;        // next output column
  logic [CNT_W-1:0] or_q, or_d;        // next output row
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_col_q, out_col_d;
  logic [CNT_W-1:0] out_row_q, out_row_d;
  logic             border_q, border_d;
  logic             eol_q, eol_d;
  logic             eof_q, eof_d;
  logic             frame_done_q, frame_done_d;

  logic in_ready;
  logic accept;
  logic in_flush;
  logic pipe_en;
  logic produce;

  // Handshake and strobes
  always_comb begin
    in_ready = !resetn && (state_q == S_IDLE || state_q == S_FILL ||
                           state_q == S_STREAM);
    accept   = bus.input_data_valid && in_ready;
    in_flush = (state_q == S_FLUSH);
    pipe_en  = in_flush ? !resetn : accept;
    // Only STREAM/FLUSH advances produce an output pixel one clock later
    produce  = pipe_en && (state_q == S_STREAM || in_flush);
  end

  // Next-state, counters and registered output tags
  always_comb begin
    state_d      = state_q;
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    oc_d         = oc_q;
    or_d         = or_q;
    flush_cnt_d  = flush_cnt_q;
    out_valid_d  = produce;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    border_d     = 1'b0;
    eol_d        = 1'b0;
    eof_d        = 1'b0;
    frame_done_d = (state_q == S_DONE);

    if (accept) begin
      if (in_col_q == LAST_COL) begin
        in_col_d = '0;
        in_row_d = in_row_q + ONE;
      end else begin
        in_col_d = in_col_q + ONE;
      end
    end

    if (produce) begin
      out_col_d = oc_q;
      out_row_d = or_q;
      border_d  = (or_q == '0) || (or_q == LAST_ROW) ||
                  (oc_q == '0) || (oc_q == LAST_COL);
      eol_d     = (oc_q == LAST_COL);
      eof_d     = (oc_q == LAST_COL) && (or_q == LAST_ROW);
      if (oc_q == LAST_COL) begin
        oc_d = '0;
        or_d = or_q + ONE;
      end else begin
        oc_d = oc_q + ONE;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        // Pixel index 0 can never be index LAG-1 because IMAGE_WIDTH >= 2
        if (accept) state_d = S_FILL;
      end
      S_FILL: begin
        // Pixel index LAG-1 = IMAGE_WIDTH sits at row 1, column 0
        if (accept && in_row_q == ONE && in_col_q == '0) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept && in_row_q == LAST_ROW && in_col_q == LAST_COL) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + ONE;
        if (flush_cnt_q == FLUSH_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        in_col_d    = '0;
        in_row_d    = '0;
        oc_d        = '0;
        or_d        = '0;
        flush_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= S_IDLE;
      in_col_q     <= '0;
      in_row_q     <= '0;
      oc_q         <= '0;
      or_q         <= '0;
      flush_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      border_q     <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      oc_q         <= oc_d;
      or_q         <= or_d;
      flush_cnt_q  <= flush_cnt_d;
      out_valid_q  <= out_valid_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      border_q     <= border_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SOBEL_CTRL_OVF_EN
  logic        drop;
  logic        drop_err_q, drop_err_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop       = bus.input_data_valid && !in_ready && !resetn;
    drop_err_d = drop_err_q || drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_err_q <= drop_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_err = drop_err_q;
  assign bus.drop_cnt = drop_cnt_q;
`endif

  assign bus.in_ready   = in_ready;
  assign bus.pipe_en    = pipe_en;
  assign bus.flush      = pipe_en && in_flush;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_row    = out_row_q;
  assign bus.border     = border_q;
  assign bus.eol        = eol_q;
  assign bus.eof        = eof_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Testbench for sobel_stream_ctrl on a 4x3 frame (LAG = 5).
// Expected output pixels are queued when a frame is driven and popped by the
// negedge monitor whenever out_valid is seen.

module tb_sobel_stream_ctrl;
  localparam int W     = 4;
  localparam int H     = 3;
  localparam int CNT_W = 12;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  sobel_stream_ctrl_if #(.CNT_W(CNT_W)) bus ();

  sobel_stream_ctrl #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             border;
    logic             eol;
    logic             eof;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int mon_out, mon_eol, mon_fd, mon_flush, mon_pipe, mon_inner;
  int first_out_cyc, mon_eof_cyc, mon_fd_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.pipe_en === 1'b1) mon_pipe++;
    if (bus.flush === 1'b1) mon_flush++;
    if (bus.frame_done === 1'b1) begin
      mon_fd++;
      mon_fd_cyc = cyc;
    end
    if (bus.out_valid === 1'b1) begin
      mon_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (bus.eol === 1'b1) mon_eol++;
      if (bus.eof === 1'b1) mon_eof_cyc = cyc;
      if (bus.border === 1'b0) mon_inner++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got col=%0d row=%0d, required no output",
                 bus.out_col, bus.out_row);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_col !== e.col || bus.out_row !== e.row ||
            bus.border !== e.border || bus.eol !== e.eol || bus.eof !== e.eof) begin
          errors++;
          $display("FAIL output_pixel: got col=%0d row=%0d border=%b eol=%b eof=%b, required col=%0d row=%0d border=%b eol=%b eof=%b",
                   bus.out_col, bus.out_row, bus.border, bus.eol, bus.eof,
                   e.col, e.row, e.border, e.eol, e.eof);
        end
      end
    end else begin
      if ((bus.border | bus.eol | bus.eof) !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL tags_without_valid: got border=%b eol=%b eof=%b, required 0",
                 bus.border, bus.eol, bus.eof);
      end
    end
  end

  task automatic clear_mon();
    mon_out = 0; mon_eol = 0; mon_fd = 0; mon_flush = 0; mon_pipe = 0; mon_inner = 0;
    first_out_cyc = -1; mon_eof_cyc = -1; mon_fd_cyc = -1;
  endtask

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.col    = CNT_W'(c);
        e.row    = CNT_W'(r);
        e.border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
        e.eol    = (c == W - 1);
        e.eof    = (c == W - 1) && (r == H - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int target_fd);
    int n = 0;
    while (mon_fd < target_fd && n < 60) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks++;
    if (mon_fd != target_fd) begin
      errors++;
      $display("FAIL frame_done_count: got %0d, required %0d", mon_fd, target_fd);
    end
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    resetn = 1'b1;
    bus.input_data_valid = 1'b1;
    tick();
    #1;
    flags = {bus.out_valid, bus.border, bus.eol, bus.eof, bus.frame_done,
             bus.busy, bus.in_ready, bus.pipe_en, bus.flush};
    checks++;
    if (flags !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000000", flags);
    end
    checks++;
    if (bus.out_col !== '0 || bus.out_row !== '0) begin
      errors++;
      $display("FAIL reset_pos: got col=%0d row=%0d, required 0 0", bus.out_col, bus.out_row);
    end
    bus.input_data_valid = 1'b0;
    resetn = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got in_ready=%b busy=%b, required 1 0",
               bus.in_ready, bus.busy);
    end
`ifdef SOBEL_CTRL_OVF_EN
    checks++;
    if (bus.drop_cnt !== 16'd0 || bus.drop_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_in_reset: got cnt=%0d err=%b, required 0 0", bus.drop_cnt, bus.drop_err);
    end
`endif
  endtask

  task automatic test_continuous();
    int c5 = -1;
    clear_mon();
    push_frame();
    for (int k = 0; k < W * H; k++) begin
      tick();
      bus.input_data_valid = 1'b1;
      if (k == 5) c5 = cyc;
    end
    tick();
    bus.input_data_valid = 1'b0;
    drain(1);
    checks++;
    if (first_out_cyc != c5 + 1) begin
      errors++;
      $display("FAIL first_out_latency: got cycle %0d, required %0d", first_out_cyc, c5 + 1);
    end
    checks++;
    if (mon_out != 12) begin
      errors++;
      $display("FAIL cont_out_count: got %0d, required 12", mon_out);
    end
    checks++;
    if (mon_flush != 5) begin
      errors++;
      $display("FAIL cont_flush_count: got %0d, required 5", mon_flush);
    end
    checks++;
    if (mon_pipe != 17) begin
      errors++;
      $display("FAIL cont_pipe_en_count: got %0d, required 17", mon_pipe);
    end
    checks++;
    if (mon_eol != 3) begin
      errors++;
      $display("FAIL cont_eol_count: got %0d, required 3", mon_eol);
    end
    checks++;
    if (mon_inner != 2) begin
      errors++;
      $display("FAIL cont_inner_count: got %0d, required 2", mon_inner);
    end
    checks++;
    if (mon_eof_cyc < 0 || mon_fd_cyc != mon_eof_cyc + 1) begin
      errors++;
      $display("FAIL frame_done_align: got cycle %0d, required %0d", mon_fd_cyc, mon_eof_cyc + 1);
    end
    checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_end: got pending=%0d busy=%b, required 0 0", exp_q.size(), bus.busy);
    end
  endtask

  task automatic test_toggle();
    logic v;
    clear_mon();
    push_frame();
    for (int k = 0; k < 2 * W * H - 1; k++) begin
      tick();
      v = (k % 2 == 0);
      bus.input_data_valid = v;
      #1;
      checks++;
      if (bus.pipe_en !== v) begin
        errors++;
        $display("FAIL toggle_pipe_en: slot %0d got %b, required %b", k, bus.pipe_en, v);
      end
    end
    tick();
    bus.input_data_valid = 1'b0;
    drain(1);
    checks++;
    if (mon_out != 12 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL toggle_out_count: got %0d pending %0d, required 12 pending 0",
               mon_out, exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] flags;
    clear_mon();
    push_frame();
    for (int k = 0; k < 8; k++) begin
      tick();
      bus.input_data_valid = 1'b1;
    end
    tick();
    bus.input_data_valid = 1'b0;
    resetn = 1'b1;
    #1;
    flags = {bus.out_valid, bus.border, bus.eol, bus.eof, bus.frame_done,
             bus.busy, bus.in_ready, bus.pipe_en, bus.flush};
    checks++;
    if (flags !== 9'b0 || bus.out_col !== '0 || bus.out_row !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got flags=%b col=%0d row=%0d, required 0",
               flags, bus.out_col, bus.out_row);
    end
    checks++;
    if (mon_out != 2) begin
      errors++;
      $display("FAIL pre_reset_outputs: got %0d, required 2", mon_out);
    end
    tick();
    resetn = 1'b0;
    exp_q.delete();
    clear_mon();
    push_frame();
    for (int k = 0; k < W * H; k++) begin
      tick();
      bus.input_data_valid = 1'b1;
    end
    tick();
    bus.input_data_valid = 1'b0;
    drain(1);
    checks++;
    if (mon_out != 12 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_frame: got %0d pending %0d, required 12 pending 0",
               mon_out, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    push_frame();
    push_frame();
    for (int k = 0; k < 2 * W * H + 6; k++) begin
      tick();
      bus.input_data_valid = 1'b1;
      #1;
      if (k >= 12 && k < 18) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL flush_in_ready: slot %0d got %b, required 0", k, bus.in_ready);
        end
      end else if (k == 18) begin
        checks++;
        if (bus.in_ready !== 1'b1 || bus.pipe_en !== 1'b1) begin
          errors++;
          $display("FAIL min_gap_restart: got in_ready=%b pipe_en=%b, required 1 1",
                   bus.in_ready, bus.pipe_en);
        end
      end
    end
    tick();
    bus.input_data_valid = 1'b0;
    drain(2);
    checks++;
    if (mon_out != 24 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_out_count: got %0d pending %0d, required 24 pending 0",
               mon_out, exp_q.size());
    end
    checks++;
    if (mon_flush != 10) begin
      errors++;
      $display("FAIL b2b_flush_count: got %0d, required 10", mon_flush);
    end
`ifdef SOBEL_CTRL_OVF_EN
    checks++;
    if (bus.drop_cnt !== 16'd6 || bus.drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_monitor: got cnt=%0d err=%b, required 6 1", bus.drop_cnt, bus.drop_err);
    end
`endif
  endtask

  initial begin
    bus.input_data_valid = 1'b0;
    clear_mon();
    test_reset();
    test_continuous();
    test_toggle();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sobel_stream_ctrl.md
Name: sobel_stream_ctrl

Overview:
- Frame sequencer for the Sobel 3x3 filter datapath.
- Counts incoming pixel positions in raster order and issues the datapath advance strobe (pipe_en).
- Tracks the output raster position, lagged by one line plus one pixel, and flags border pixels so the datapath can force them to 0.
- After the last input pixel, generates the flush strobes that drain the line buffers, so each frame yields exactly IMAGE_WIDTH*IMAGE_HEIGHT outputs.

Parameters:
- IMAGE_WIDTH, 640, pixels per line (>=2)
- IMAGE_HEIGHT, 480, lines per frame (>=2)
- CNT_W, 12, width of the column, row and flush counters; must hold max(IMAGE_WIDTH, IMAGE_HEIGHT, IMAGE_WIDTH+1)

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-high reset (name kept from the codebase; 1 = in reset)
- input_data_valid  in  1  input pixel present this cycle
- in_ready  out  1  controller accepts input this cycle
- pipe_en  out  1  advance datapath line buffers and window (combinational)
- flush  out  1  high on pipe_en cycles in FLUSH; datapath injects 0 as pixel
- out_valid  out  1  registered; datapath output pixel valid
- out_col  out  CNT_W  registered column of the current output pixel
- out_row  out  CNT_W  registered row of the current output pixel
- border  out  1  registered; out_valid and output pixel on row 0, row H-1, col 0 or col W-1
- eol  out  1  registered; out_valid and out_col==W-1
- eof  out  1  registered; out_valid and last pixel of the frame
- frame_done  out  1  one-cycle pulse, one cycle after eof
- busy  out  1  state != IDLE

Behaviour:
- LAG = IMAGE_WIDTH+1; accept = input_data_valid & in_ready.
- Reset (async, any time, including mid-frame): state=IDLE, all counters 0. out_valid, border, eol, eof, frame_done, busy = 0. in_ready is forced 0 while resetn=1.
- in_ready = 1 in IDLE, FILL and STREAM; 0 in FLUSH and DONE.
- Input valid while in_ready=0 is dropped, and no counter moves.
- pipe_en = accept in IDLE, FILL and STREAM; pipe_en = 1 every cycle in FLUSH. flush = pipe_en in FLUSH.
- in_col/in_row advance on accept. in_col wraps W-1 -> 0 with in_row+1.
- Output generation: out_valid(t+1) = 1 iff pipe_en(t) was in STREAM or FLUSH.
- out_col/out_row start at 0,0 and advance raster-wise after each out_valid, wrapping like the input counters.
- Output latency from the input pixel with raster index k to the output pixel with index k-LAG is one clock.
- FSM:
  - IDLE: first accept -> FILL (this pixel is index 0). If LAG==1 (not reachable, since W>=2) it would go to STREAM.
  - FILL: accept of pixel index LAG-1 -> STREAM. No outputs in this state.
  - STREAM: each accept produces one output. Accept of pixel index W*H-1 -> FLUSH, flush_cnt=0.
  - FLUSH: flush_cnt increments each cycle. At flush_cnt==LAG-1 -> DONE. This gives exactly LAG flush strobes, and W*H outputs total.
  - DONE: one cycle, frame_done=1 next cycle... (registered pulse aligned one cycle after the eof cycle) -> IDLE. All counters are cleared.
- Gaps in input_data_valid in FILL/STREAM stall everything; no outputs are generated during a gap.
- Back-to-back frames: input resumes only once in_ready=1 (in IDLE). The minimum inter-frame gap is LAG+1 cycles.

Optional Feature:
- Macro SOBEL_CTRL_OVF_EN.
- Defined: adds output drop_err (1 bit, sticky) and drop_cnt (16 bits, saturating at 0xFFFF).
  - Both increment/set when input_data_valid=1 and in_ready=0 outside reset.
  - Both are cleared only by reset.
- Not defined: these ports are absent. Dropped inputs are silently ignored.

Test Plan:
- W=4,H=3, continuous valid for 12 cycles: first out_valid at the cycle after the 6th input. 7 outputs occur during STREAM, then 5 flush strobes with flush=1. Total out_valid count = 12.
- Same frame: border=1 for all outputs except (row1,col1) and (row1,col2). eol on out_col=3 (3 pulses). eof with out_row=2,out_col=3. frame_done one cycle later. busy falls after DONE.
- Valid toggling 1/0 every cycle: pipe_en only on valid cycles. Output order and count identical to the continuous case (12, raster order).
- Assert resetn for 1 cycle after the 8th input: all outputs 0 immediately. Then a fresh 12-pixel frame produces 12 outputs starting at (0,0).
- Hold valid=1 through FLUSH and DONE (5+1 cycles): no counter change, output count still 12. With SOBEL_CTRL_OVF_EN, drop_cnt=6 and drop_err=1.
- Default 640x480 frame: 307200 outputs, 480 eol pulses, exactly one frame_done.
